// File: rtl/operand_scoreboard.sv
// Per-register latency scoreboard for decode-stage operand hazards.
// Forwards from the shared result bus and requests a stall while a source register is still pending.
module operand_scoreboard #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NRD     = 2,
    parameter int unsigned MAX_LAT = 4,
    localparam int unsigned LATW   = $clog2(MAX_LAT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_wreg,
    input  logic [4:0]            issue_waddr,
    input  logic [LATW-1:0]       issue_lat,
    input  logic                  flush,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*5-1:0]      rd_addr,
    input  logic [NRD*XLEN-1:0]   rf_data,
    input  logic                  res_valid,
    input  logic [4:0]            res_addr,
    input  logic [XLEN-1:0]       res_data,
    output logic [NRD*XLEN-1:0]   operand,
    output logic                  stall,
    output logic [31:0]           busy_mask,
    output logic [31:0]           stall_cycles
);

    localparam int unsigned NREG = 32;
    localparam int unsigned SCW  = 32;

    logic [LATW-1:0] cnt_q [NREG];
    logic [LATW-1:0] cnt_d [NREG];
    logic [SCW-1:0]  stall_cycles_q;
    logic [SCW-1:0]  stall_cycles_d;
    logic [LATW-1:0] lat_clamped;
    logic [NRD-1:0]  port_stall;
    logic            accept;

    // Latency clamp: zero behaves as one cycle, oversize saturates at MAX_LAT
    always_comb begin
        lat_clamped = issue_lat;
        if (issue_lat == '0) begin
            lat_clamped = LATW'(1);
        end else if (issue_lat > LATW'(MAX_LAT)) begin
            lat_clamped = LATW'(MAX_LAT);
        end
    end

    // Per-port forwarding and hazard detection
    always_comb begin
        operand    = rf_data;
        port_stall = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            logic [4:0]      a;
            logic [LATW-1:0] c;
            logic            hit;
            a   = rd_addr[5*i +: 5];
            c   = cnt_q[a];
            hit = res_valid && (res_addr == a) && (a != 5'd0);
            if (hit) begin
                operand[XLEN*i +: XLEN] = res_data;
            end
            port_stall[i] = rd_en[i] && (a != 5'd0) &&
                            ((c > LATW'(1)) || ((c == LATW'(1)) && !hit));
        end
    end

    assign stall  = |port_stall;
    assign accept = issue_valid && !stall && !flush;

    // Counter next state: decrement, then issue load overrides, flush clears everything
    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LATW'(1) : '0;
        end
        if (accept && issue_wreg && (issue_waddr != 5'd0)) begin
            cnt_d[issue_waddr] = lat_clamped;
        end
        if (flush) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_d[r] = '0;
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + SCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_operand_scoreboard.sv
// Bench for operand_scoreboard: directed vector table, then random traffic against a due-cycle model.
module tb_operand_scoreboard;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NRD     = 2;
    localparam int unsigned MAX_LAT = 4;
    localparam int unsigned LATW    = $clog2(MAX_LAT + 1);
    localparam logic [31:0] RF0     = 32'hAAAA_0000;
    localparam logic [31:0] RF1     = 32'hBBBB_0000;

    logic                clk = 1'b0;
    logic                rst;
    logic                issue_valid;
    logic                issue_wreg;
    logic [4:0]          issue_waddr;
    logic [LATW-1:0]     issue_lat;
    logic                flush;
    logic [NRD-1:0]      rd_en;
    logic [NRD*5-1:0]    rd_addr;
    logic [NRD*XLEN-1:0] rf_data;
    logic                res_valid;
    logic [4:0]          res_addr;
    logic [XLEN-1:0]     res_data;
    logic [NRD*XLEN-1:0] operand;
    logic                stall;
    logic [31:0]         busy_mask;
    logic [31:0]         stall_cycles;

    operand_scoreboard #(.XLEN(XLEN), .NRD(NRD), .MAX_LAT(MAX_LAT)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_wreg(issue_wreg),
        .issue_waddr(issue_waddr), .issue_lat(issue_lat),
        .flush(flush), .rd_en(rd_en), .rd_addr(rd_addr), .rf_data(rf_data),
        .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
        .operand(operand), .stall(stall), .busy_mask(busy_mask),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        rst;
        bit        iv;
        bit        wreg;
        bit [4:0]  waddr;
        bit [2:0]  lat;
        bit        flush;
        bit        en0;
        bit [4:0]  a0;
        bit        rv;
        bit [4:0]  raddr;
        bit [31:0] rdata;
        bit        do_chk;
        bit        e_stall;
        bit [31:0] e_busy;
        bit [31:0] e_op0;
        bit [31:0] e_sc;
    } vec_t;

    function automatic vec_t mk(bit r, bit iv, bit wr, bit [4:0] wa, bit [2:0] lat, bit fl,
                                bit en0, bit [4:0] a0, bit rv, bit [4:0] ra, bit [31:0] rd,
                                bit c, bit es, bit [31:0] eb, bit [31:0] eo, bit [31:0] esc);
        vec_t v;
        v.rst = r; v.iv = iv; v.wreg = wr; v.waddr = wa; v.lat = lat; v.flush = fl;
        v.en0 = en0; v.a0 = a0; v.rv = rv; v.raddr = ra; v.rdata = rd;
        v.do_chk = c; v.e_stall = es; v.e_busy = eb; v.e_op0 = eo; v.e_sc = esc;
        return v;
    endfunction

    // Reference model: absolute cycle at which each register's result is on the bus
    int    due [32];
    int    cyc;
    longint sc_model;

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) due[r] = -1;
        sc_model = 0;
    endfunction

    initial begin
        vec_t vecs [$];
        logic [31:0] e_busy;
        logic [NRD*XLEN-1:0] e_op;
        bit e_stall;

        rst = 1'b1; issue_valid = 1'b0; issue_wreg = 1'b0; issue_waddr = '0;
        issue_lat = '0; flush = 1'b0; rd_en = '0; rd_addr = '0;
        rf_data = {RF1, RF0}; res_valid = 1'b0; res_addr = '0; res_data = '0;

        vecs.push_back(mk(1,1,1, 5,2,0, 0, 0, 0, 0,32'h0,        0, 0,32'h000,RF0,0));
        vecs.push_back(mk(1,1,1, 5,2,0, 0, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,0));
        vecs.push_back(mk(0,1,1, 5,1,0, 0, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1, 5, 1, 5,32'hDEADBEEF, 1, 0,32'h020,32'hDEADBEEF,0));
        vecs.push_back(mk(0,1,1, 7,2,0, 0, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,0));
        vecs.push_back(mk(0,1,1, 8,1,0, 1, 7, 0, 0,32'h0,        1, 1,32'h080,RF0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 1, 7, 1, 7,32'h12345678, 1, 0,32'h080,32'h12345678,1));
        vecs.push_back(mk(0,1,1, 0,3,0, 1, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,1));
        vecs.push_back(mk(0,1,1, 9,4,0, 1, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,1));
        vecs.push_back(mk(0,1,1, 9,1,0, 0, 0, 0, 0,32'h0,        1, 0,32'h200,RF0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, 0, 0, 0,32'h0,        1, 0,32'h200,RF0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,1));
        vecs.push_back(mk(0,1,1, 3,4,0, 0, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,1));
        vecs.push_back(mk(0,1,1, 4,2,1, 0, 0, 0, 0,32'h0,        1, 0,32'h008,RF0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 1, 3, 0, 0,32'h0,        1, 0,32'h000,RF0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 1, 4, 0, 0,32'h0,        1, 0,32'h000,RF0,1));
        vecs.push_back(mk(0,1,1,10,0,0, 0, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 0, 0,32'h0,        1, 1,32'h400,RF0,1));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,10, 0, 0,32'h0,        1, 0,32'h000,RF0,2));
        vecs.push_back(mk(0,1,1,11,7,0, 0, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,2));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, 0, 0, 0,32'h0,        1, 0,32'h800,RF0,2));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,11, 0, 0,32'h0,        1, 1,32'h800,RF0,2));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,11, 0, 0,32'h0,        1, 1,32'h800,RF0,3));
        vecs.push_back(mk(0,0,0, 0,0,0, 1,11, 1,11,32'h55,       1, 0,32'h800,32'h55,4));
        vecs.push_back(mk(0,0,0, 0,0,0, 0, 0, 0, 0,32'h0,        1, 0,32'h000,RF0,4));

        foreach (vecs[k]) begin
            @(negedge clk);
            rst = vecs[k].rst; issue_valid = vecs[k].iv; issue_wreg = vecs[k].wreg;
            issue_waddr = vecs[k].waddr; issue_lat = LATW'(vecs[k].lat); flush = vecs[k].flush;
            rd_en = {1'b0, vecs[k].en0}; rd_addr = {5'd0, vecs[k].a0};
            rf_data = {RF1, RF0}; res_valid = vecs[k].rv; res_addr = vecs[k].raddr;
            res_data = vecs[k].rdata;
            #1;
            if (vecs[k].do_chk) begin
                chk($sformatf("vec%0d stall", k), 32'(stall), 32'(vecs[k].e_stall));
                chk($sformatf("vec%0d busy_mask", k), busy_mask, vecs[k].e_busy);
                chk($sformatf("vec%0d operand0", k), operand[31:0], vecs[k].e_op0);
                chk($sformatf("vec%0d operand1", k), operand[63:32], RF1);
                chk($sformatf("vec%0d stall_cycles", k), stall_cycles, vecs[k].e_sc);
            end
        end

        // Random traffic; first cycle resets DUT and model together
        model_reset();
        cyc = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst         = (i == 0) || ($urandom_range(0, 299) == 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_wreg  = $urandom_range(0, 3) != 0;
            issue_waddr = 5'($urandom_range(0, 7));
            issue_lat   = LATW'($urandom_range(0, 7));
            flush       = $urandom_range(0, 29) == 0;
            rd_en       = NRD'($urandom);
            rd_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rf_data     = {32'($urandom), 32'($urandom)};
            res_valid   = $urandom_range(0, 1) == 1;
            res_addr    = 5'($urandom_range(0, 7));
            res_data    = 32'($urandom);
            #1;

            e_stall = 1'b0;
            e_busy  = '0;
            e_op    = rf_data;
            for (int r = 1; r < 32; r++) e_busy[r] = (due[r] >= cyc);
            for (int p = 0; p < NRD; p++) begin
                int a;
                bit hit;
                a   = int'(rd_addr[5*p +: 5]);
                hit = res_valid && (int'(res_addr) == a) && (a != 0);
                if (hit) e_op[XLEN*p +: XLEN] = res_data;
                if (rd_en[p] && a != 0 && (due[a] > cyc || (due[a] == cyc && !hit)))
                    e_stall = 1'b1;
            end

            if (i != 0) begin
                chk("rand stall", 32'(stall), 32'(e_stall));
                chk("rand busy_mask", busy_mask, e_busy);
                chk("rand operand0", operand[31:0], e_op[31:0]);
                chk("rand operand1", operand[63:32], e_op[63:32]);
                chk("rand stall_cycles", stall_cycles, 32'(sc_model));
            end

            if (rst) begin
                model_reset();
            end else begin
                if (e_stall && sc_model < 64'hFFFF_FFFF) sc_model++;
                if (flush) begin
                    for (int r = 0; r < 32; r++) due[r] = -1;
                end else if (issue_valid && !e_stall && issue_wreg && issue_waddr != 5'd0) begin
                    int lat;
                    lat = int'(issue_lat);
                    if (lat < 1) lat = 1;
                    if (lat > int'(MAX_LAT)) lat = int'(MAX_LAT);
                    due[issue_waddr] = cyc + lat;
                end
            end
            cyc++;
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
